psum_stream_packer: RTL and testbench

//  Drains the wide MAC partial-sum vector (LANES x PSUM_W) to an AXI4-Stream master so results return to DDR via DMA.

---
 rtl/psum_stream_packer.sv | 259 +++++++++++++++++++++++++
 tb/tb_psum_stream_packer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_stream_packer.sv
// psum_stream_packer
// Captures wide MAC partial-sum vectors into a two-entry ping-pong buffer and
// drains each one as an AXI4-Stream packet. Lanes go out either as raw
// sign-extended 32-bit words or requantised to int8 (shift, round, ReLU,
// saturate). A per-vector lane count trims the final beat.
module psum_stream_packer #(
    parameter int LANES  = 64,
    parameter int PSUM_W = 20,
    parameter int AXIS_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LANES*PSUM_W-1:0]    psum_in,
    input  logic                       psum_valid,
    output logic                       psum_ready,
    input  logic [$clog2(LANES+1)-1:0] cfg_lanes,
    input  logic                       cfg_mode,
    input  logic                       cfg_relu,
    input  logic [4:0]                 cfg_shift,
    output logic [AXIS_W-1:0]          m_axis_tdata,
    output logic [AXIS_W/8-1:0]        m_axis_tkeep,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    output logic                       vec_done,
    output logic                       busy
);

    localparam int LW      = $clog2(LANES + 1);
    localparam int LIW     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int KW      = AXIS_W / 8;
    localparam int LPB_RAW = AXIS_W / 32;
    localparam int LPB_I8  = AXIS_W / 8;
    // Wide enough to hold both the requantised value and the int8 limits.
    localparam int QW      = (PSUM_W + 1 > 9) ? PSUM_W + 1 : 9;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    // Clamp a requantised value into the int8 range.
    function automatic logic [7:0] sat_int8(input logic signed [QW-1:0] t);
        if (t > QW'(127)) begin
            return 8'h7F;
        end
        if (t < QW'(-128)) begin
            return 8'h80;
        end
        return t[7:0];
    endfunction

    // Round-half-up arithmetic right shift at PSUM_W+1 bits, optional ReLU,
    // then saturate to int8.
    function automatic logic [7:0] requant(input logic signed [PSUM_W-1:0] x,
                                           input logic [4:0]               shift,
                                           input logic                     relu);
        logic signed [PSUM_W:0] ext;
        logic signed [PSUM_W:0] rnd;
        logic signed [PSUM_W:0] t;
        ext = (PSUM_W + 1)'(x);
        rnd = '0;
        if (shift != 5'd0) begin
            rnd = (PSUM_W + 1)'(1) << (shift - 5'd1);
        end
        t = (ext + rnd) >>> shift;
        if (relu && t[PSUM_W]) begin
            t = '0;
        end
        return sat_int8(QW'(t));
    endfunction

    // Sign-extend a lane to a 32-bit word, zeroing negatives under ReLU.
    function automatic logic [31:0] raw_extend(input logic signed [PSUM_W-1:0] x,
                                               input logic                     relu);
        if (relu && x[PSUM_W-1]) begin
            return 32'd0;
        end
        return 32'(x);
    endfunction

    // Ping-pong capture buffer with per-entry configuration.
    logic signed [PSUM_W-1:0] ent_lane  [2][LANES];
    logic [LW-1:0]            ent_lanes [2];
    logic                     ent_mode  [2];
    logic                     ent_relu  [2];
    logic [4:0]               ent_shift [2];

    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    occ;
    logic          capture;
    logic [LW-1:0] eff_lanes;

    state_t        state;
    state_t        state_next;
    logic [LW-1:0] beat_cnt;
    logic          vld_p0;
    logic          entry_free;

    logic [AXIS_W-1:0] beat_data_p0;
    logic [KW-1:0]     beat_keep_p0;
    logic              beat_last_p0;
    int                beat_base;
    int                rd_lanes;

    assign psum_ready = (occ != 2'd2);
    assign capture    = psum_valid && psum_ready;
    assign busy       = (occ != 2'd0) || m_axis_tvalid;
    assign eff_lanes  = ((cfg_lanes == '0) || (int'(cfg_lanes) > LANES)) ? LW'(LANES) : cfg_lanes;

    // Write the incoming vector and its configuration into the write entry.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < LANES; i++) begin
                ent_lane[wr_ptr][i] <= psum_in[i*PSUM_W +: PSUM_W];
            end
            ent_lanes[wr_ptr] <= eff_lanes;
            ent_mode[wr_ptr]  <= cfg_mode;
            ent_relu[wr_ptr]  <= cfg_relu;
            ent_shift[wr_ptr] <= cfg_shift;
        end
    end

    // Track buffer occupancy and the ping-pong pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (capture) begin
                wr_ptr <= ~wr_ptr;
            end
            if (entry_free) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({capture, entry_free})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Drain FSM next-state logic; a capture in the same cycle counts as a full entry.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (capture || (occ != 2'd0)) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                state_next = S_STREAM;
            end
            S_STREAM: begin
                if (entry_free) begin
                    state_next = ((occ == 2'd2) || capture) ? S_LOAD : S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Drain FSM outputs: when to present a new beat and when an entry retires.
    always_comb begin
        vld_p0     = 1'b0;
        entry_free = 1'b0;
        case (state)
            S_LOAD: begin
                vld_p0 = 1'b1;
            end
            S_STREAM: begin
                if (m_axis_tvalid && m_axis_tready) begin
                    if (m_axis_tlast) begin
                        entry_free = 1'b1;
                    end else begin
                        vld_p0 = 1'b1;
                    end
                end
            end
            default: begin
                vld_p0     = 1'b0;
                entry_free = 1'b0;
            end
        endcase
    end

    // Format beat beat_cnt of the read entry; lanes past the active count stay zero.
    always_comb begin
        beat_data_p0 = '0;
        beat_keep_p0 = '0;
        beat_last_p0 = 1'b0;
        beat_base    = 0;
        rd_lanes     = int'(ent_lanes[rd_ptr]);
        if (ent_mode[rd_ptr]) begin
            beat_base    = int'(beat_cnt) * LPB_I8;
            beat_last_p0 = (beat_base + LPB_I8) >= rd_lanes;
            for (int j = 0; j < LPB_I8; j++) begin
                if (beat_base + j < rd_lanes) begin
                    beat_data_p0[j*8 +: 8] = requant(ent_lane[rd_ptr][LIW'(beat_base + j)],
                                                     ent_shift[rd_ptr], ent_relu[rd_ptr]);
                    beat_keep_p0[j]        = 1'b1;
                end
            end
        end else begin
            beat_base    = int'(beat_cnt) * LPB_RAW;
            beat_last_p0 = (beat_base + LPB_RAW) >= rd_lanes;
            for (int j = 0; j < LPB_RAW; j++) begin
                if (beat_base + j < rd_lanes) begin
                    beat_data_p0[j*32 +: 32] = raw_extend(ent_lane[rd_ptr][LIW'(beat_base + j)],
                                                          ent_relu[rd_ptr]);
                    beat_keep_p0[j*4 +: 4]   = 4'hF;
                end
            end
        end
    end

    // ---- stage p0 -> AXIS output register ----
    // Register the beat; outputs only change on load or after the last beat retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            beat_cnt      <= '0;
            vec_done      <= 1'b0;
        end else begin
            vec_done <= entry_free;
            if (vld_p0) begin
                m_axis_tdata  <= beat_data_p0;
                m_axis_tkeep  <= beat_keep_p0;
                m_axis_tlast  <= beat_last_p0;
                m_axis_tvalid <= 1'b1;
                beat_cnt      <= beat_cnt + LW'(1);
            end else if (entry_free) begin
                m_axis_tdata  <= '0;
                m_axis_tkeep  <= '0;
                m_axis_tlast  <= 1'b0;
                m_axis_tvalid <= 1'b0;
                beat_cnt      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_psum_stream_packer.sv
// tb_psum_stream_packer
// Directed bench: raw and int8 packing, partial lane counts, back-to-back
// vectors, random back-pressure with a scoreboard, and reset mid-vector.
module tb_psum_stream_packer;

    localparam int LANES  = 64;
    localparam int PSUM_W = 20;
    localparam int AXIS_W = 32;
    localparam int LW     = $clog2(LANES + 1);
    localparam int KW     = AXIS_W / 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [LANES*PSUM_W-1:0] psum_in;
    logic                    psum_valid;
    logic                    psum_ready;
    logic [LW-1:0]           cfg_lanes;
    logic                    cfg_mode;
    logic                    cfg_relu;
    logic [4:0]              cfg_shift;
    logic [AXIS_W-1:0]       m_axis_tdata;
    logic [KW-1:0]           m_axis_tkeep;
    logic                    m_axis_tvalid;
    logic                    m_axis_tlast;
    logic                    m_axis_tready;
    logic                    vec_done;
    logic                    busy;

    typedef struct packed {
        logic [AXIS_W-1:0] d;
        logic [KW-1:0]     k;
        logic              l;
    } beat_t;

    beat_t got_q[$];
    beat_t exp_q[$];
    int    got_cyc[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    done_cnt = 0;
    int    cyc = 0;
    logic  rand_ready = 1'b0;
    logic  ready_force = 1'b1;
    logic  stall_prev = 1'b0;
    beat_t cur;
    beat_t hold;

    psum_stream_packer #(.LANES(LANES), .PSUM_W(PSUM_W), .AXIS_W(AXIS_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .psum_in       (psum_in),
        .psum_valid    (psum_valid),
        .psum_ready    (psum_ready),
        .cfg_lanes     (cfg_lanes),
        .cfg_mode      (cfg_mode),
        .cfg_relu      (cfg_relu),
        .cfg_shift     (cfg_shift),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .vec_done      (vec_done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Downstream ready: forced level or 50% random stalls.
    always @(posedge clk) begin
        #2;
        m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, got, exp);
        end
    endtask

    // Beat collector and stall-stability checker, sampled mid-cycle.
    always @(negedge clk) begin
        cur = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_beat", 64'(cur), 64'(hold));
                chk("hold_valid", 64'(m_axis_tvalid), 64'(1));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                got_q.push_back(cur);
                got_cyc.push_back(cyc);
            end
            if (vec_done) done_cnt++;
            stall_prev = m_axis_tvalid && !m_axis_tready;
            hold = cur;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] ref_q8(input int x, input int sh, input bit relu);
        longint t;
        t = longint'(x);
        if (sh > 0) t = t + (longint'(1) << (sh - 1));
        t = t >>> sh;
        if (relu && t < 0) t = 0;
        if (t > 127) t = 127;
        if (t < -128) t = -128;
        return 8'(t);
    endfunction

    task automatic model_push(input int v[LANES], input int lcfg, input bit mode,
                              input bit relu, input int sh);
        int L, lpb, nb, ln;
        beat_t e;
        logic [31:0] w;
        L   = (lcfg == 0 || lcfg > LANES) ? LANES : lcfg;
        lpb = mode ? AXIS_W / 8 : AXIS_W / 32;
        nb  = (L + lpb - 1) / lpb;
        for (int b = 0; b < nb; b++) begin
            e   = '0;
            e.l = (b == nb - 1);
            for (int j = 0; j < lpb; j++) begin
                ln = b * lpb + j;
                if (ln < L) begin
                    if (mode) begin
                        e.d |= AXIS_W'(ref_q8(v[ln], sh, relu)) << (j * 8);
                        e.k |= KW'(1) << j;
                    end else begin
                        w = (relu && v[ln] < 0) ? 32'd0 : 32'(v[ln]);
                        e.d |= AXIS_W'(w) << (j * 32);
                        e.k |= KW'(4'hF) << (j * 4);
                    end
                end
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input int v[LANES], input int lcfg, input bit mode, input bit relu,
                        input int sh, output int seen);
        int t;
        psum_in = '0;
        for (int i = 0; i < LANES; i++)
            psum_in |= (LANES*PSUM_W)'($unsigned(PSUM_W'(v[i]))) << (i * PSUM_W);
        cfg_lanes  = LW'(lcfg);
        cfg_mode   = mode;
        cfg_relu   = relu;
        cfg_shift  = 5'(sh);
        psum_valid = 1'b1;
        t = 0;
        while (!psum_ready && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (!psum_ready) chk("send_ready", 64'(psum_ready), 64'(1));
        seen = got_q.size();
        @(posedge clk); #1;
        psum_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int t;
        t = 0;
        while (got_q.size() < n && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        if (got_q.size() < n) chk("beats_arrived", 64'(got_q.size()), 64'(n));
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    initial begin
        int v[LANES];
        int seen;
        logic [31:0] ed;

        rst = 1'b1;
        psum_valid = 1'b0;
        psum_in = '0;
        cfg_lanes = '0;
        cfg_mode = 1'b0;
        cfg_relu = 1'b0;
        cfg_shift = 5'd0;
        settle(3);

        // Reset state
        chk("rst_outputs", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid, vec_done, busy}), 64'(0));
        chk("rst_ready", 64'(psum_ready), 64'(1));
        rst = 1'b0;
        settle(2);

        // Raw, 64 lanes, lane i = i-32
        clear_q();
        for (int i = 0; i < LANES; i++) v[i] = i - 32;
        send(v, 64, 1'b0, 1'b0, 0, seen);
        chk("lat_load_cycle", 64'(m_axis_tvalid), 64'(0));
        settle(1);
        chk("lat_tvalid", 64'(m_axis_tvalid), 64'(1));
        wait_beats(64, 500);
        settle(3);
        chk("raw_nbeats", 64'(got_q.size()), 64'(64));
        for (int i = 0; i < 64 && i < got_q.size(); i++) begin
            ed = i - 32;
            chk("raw_data", 64'(got_q[i].d), 64'(ed));
            chk("raw_keep_last", 64'({got_q[i].k, got_q[i].l}), 64'({4'hF, 1'(i == 63)}));
        end
        chk("raw_vec_done", 64'(done_cnt), 64'(1));
        chk("raw_idle_busy", 64'(busy), 64'(0));

        // int8 shift 4 with saturation
        clear_q();
        for (int i = 0; i < LANES; i++) v[i] = 0;
        v[0] = 100; v[1] = -100; v[2] = 40000; v[3] = -40000;
        send(v, 4, 1'b1, 1'b0, 4, seen);
        wait_beats(1, 100);
        settle(3);
        chk("i8_nbeats", 64'(got_q.size()), 64'(1));
        if (got_q.size() > 0) begin
            chk("i8_sat_data", 64'(got_q[0].d), 64'(32'h807FFA06));
            chk("i8_sat_keep_last", 64'({got_q[0].k, got_q[0].l}), 64'({4'hF, 1'b1}));
        end
        chk("i8_vec_done", 64'(done_cnt), 64'(1));

        // int8 relu, 6 lanes, shift 4
        clear_q();
        for (int i = 0; i < LANES; i++) v[i] = 1000;
        v[0] = 80; v[1] = -48; v[2] = 3200; v[3] = -1; v[4] = 8; v[5] = 24;
        send(v, 6, 1'b1, 1'b1, 4, seen);
        wait_beats(2, 100);
        settle(3);
        chk("relu_nbeats", 64'(got_q.size()), 64'(2));
        if (got_q.size() > 1) begin
            chk("relu_b0_data", 64'(got_q[0].d), 64'(32'h007F0005));
            chk("relu_b0_keep_last", 64'({got_q[0].k, got_q[0].l}), 64'({4'hF, 1'b0}));
            chk("relu_b1_data", 64'(got_q[1].d), 64'(32'h00000201));
            chk("relu_b1_keep_last", 64'({got_q[1].k, got_q[1].l}), 64'({4'h3, 1'b1}));
        end

        // Three raw vectors back-to-back, tready held high
        clear_q();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < LANES; i++) v[i] = (k + 1) * 1000 - i * 37;
            model_push(v, 64, 1'b0, 1'b0, 0);
            send(v, 64, 1'b0, 1'b0, 0, seen);
            if (k == 1) chk("b2b_ready_full", 64'(psum_ready), 64'(0));
            if (k == 2) chk("b2b_ready_at_tlast", 64'(seen), 64'(64));
        end
        wait_beats(192, 1000);
        settle(3);
        chk("b2b_nbeats", 64'(got_q.size()), 64'(192));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk("b2b_beat", 64'(got_q[i]), 64'(exp_q[i]));
        if (got_cyc.size() >= 192) chk("b2b_span_cycles", 64'(got_cyc[191] - got_cyc[0]), 64'(193));
        chk("b2b_vec_done", 64'(done_cnt), 64'(3));

        // Random back-pressure, mixed modes and lane counts
        clear_q();
        rand_ready = 1'b1;
        for (int i = 0; i < LANES; i++) v[i] = i * 53 - 1500;
        model_push(v, 37, 1'b1, 1'b0, 3);
        send(v, 37, 1'b1, 1'b0, 3, seen);
        for (int i = 0; i < LANES; i++) v[i] = (i % 2 == 1) ? -i * 1000 : i * 999;
        model_push(v, 0, 1'b0, 1'b1, 0);
        send(v, 0, 1'b0, 1'b1, 0, seen);
        for (int i = 0; i < LANES; i++) v[i] = i * 9 - 290;
        model_push(v, 100, 1'b1, 1'b1, 0);
        send(v, 100, 1'b1, 1'b1, 0, seen);
        wait_beats(90, 3000);
        rand_ready = 1'b0;
        settle(4);
        chk("stall_nbeats", 64'(got_q.size()), 64'(90));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk("stall_beat", 64'(got_q[i]), 64'(exp_q[i]));
        chk("stall_vec_done", 64'(done_cnt), 64'(3));

        // Reset in the middle of a vector
        clear_q();
        for (int i = 0; i < LANES; i++) v[i] = i + 500;
        send(v, 64, 1'b0, 1'b0, 0, seen);
        wait_beats(10, 200);
        rst = 1'b1;
        #1;
        chk("rstmid_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("rstmid_ready", 64'(psum_ready), 64'(1));
        chk("rstmid_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        clear_q();
        for (int i = 0; i < LANES; i++) v[i] = 0;
        v[0] = -5; v[1] = 9;
        send(v, 2, 1'b0, 1'b0, 0, seen);
        wait_beats(2, 100);
        settle(3);
        chk("rstmid_nbeats", 64'(got_q.size()), 64'(2));
        if (got_q.size() > 1) begin
            chk("rstmid_b0", 64'(got_q[0]), 64'({32'hFFFFFFFB, 4'hF, 1'b0}));
            chk("rstmid_b1", 64'(got_q[1]), 64'({32'h00000009, 4'hF, 1'b1}));
        end
        chk("rstmid_vec_done", 64'(done_cnt), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
